shift_word: RTL

// - Parametrised serial<->parallel shift engine for bit-serial links between ice40 logic and the host/MCU side.
// - Shifts serial data in and out under a per-cycle enable.
// - Counts bits and presents each completed word on a valid/ready parallel output.
// - Supports parallel preload of the transmit word, selectable bit order and overrun detection.

---
 rtl/shift_word.sv | 126 ++++++++++++
 1 files changed

// File: rtl/shift_word.sv
// shift_word: serial<->parallel shift engine for bit-serial links.
//
// Serial bits shift in and out one per cycle while enable is high. A bit
// counter marks word boundaries. Each completed word goes to a valid/ready
// parallel output. The transmit word can be preloaded in parallel. The bit
// order is selectable. A sticky flag records any completed word that was
// dropped because the consumer had not taken the previous one.
//
// Parameters
//   WIDTH      word width in bits (2..32)
//   MSB_FIRST  0: shift toward bit 0 (LSB first), 1: shift toward bit WIDTH-1
//   INIT       shift register value after reset
//
// Ports
//   clk         in   clock, all logic on posedge
//   reset       in   synchronous active-high reset
//   enable      in   shift one bit this cycle
//   in          in   serial data in, sampled when enable=1
//   out         out  serial data out, shift register end bit (combinational)
//   load        in   parallel preload request (priority over enable)
//   load_value  in   value written to the shift register on load
//   bit_count   out  bits shifted into the current word
//   word_out    out  last completed received word
//   word_valid  out  word_out holds an unconsumed word
//   word_ready  in   consumer accepts word_out when word_valid=1
//   overrun     out  sticky: a completed word was dropped
module shift_word #(
  parameter int              WIDTH     = 8,
  parameter bit              MSB_FIRST = 1'b0,
  parameter logic [WIDTH-1:0] INIT     = 'hAA,
  localparam int             CW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in,
  output logic             out,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [CW-1:0]    bit_count,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overrun
);

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0] shifted;
  logic             complete;

  // Shift direction is fixed at elaboration. The serial output is the bit
  // that leaves the register on the next shift.
  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {sreg_q[WIDTH-2:0], in};
      assign out     = sreg_q[WIDTH-1];
    end else begin : g_lsb
      assign shifted = {in, sreg_q[WIDTH-1:1]};
      assign out     = sreg_q[0];
    end
  endgenerate

  // A load takes priority over a shift. A load therefore never completes a
  // word, and the partial word it replaces is discarded.
  assign complete = enable && !load && (cnt_q == LAST_BIT);

  always_comb begin
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (load) begin
      sreg_d = load_value;
      cnt_d  = '0;
    end else if (enable) begin
      sreg_d = shifted;
      cnt_d  = complete ? '0 : cnt_q + 1'b1;
    end

    // Consumption frees the output slot. A completion in the same cycle can
    // refill it immediately.
    if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end

    if (complete) begin
      if (!valid_q || word_ready) begin
        word_d  = shifted;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg_q  <= INIT;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bit_count  = cnt_q;
  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign overrun    = ovr_q;

endmodule
